// File: rtl/aux_uart_tx.sv
// Auxiliary UART transmitter: byte FIFO feeding an LSB-first serial framer.
// Define AUX_UART_TX_PARITY_EN for 8E1 frames; otherwise frames are 8N1.
module aux_uart_tx #(
   parameter int CLK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE     = 115_200,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

`ifdef AUX_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
`ifdef AUX_UART_TX_PARITY_EN
   logic          parity_bit;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          bit_end;

   assign full     = (fifo_count == FULL_COUNT);
   assign empty    = (fifo_count == '0);
   assign tx_ready = !full;
   assign push     = tx_valid && !full;
   assign head     = mem[rd_ptr];
   assign bit_end  = (baud_cnt == '0);
   assign busy     = (state != S_IDLE) || !empty;

   // Pop when idle, or at the end of a stop bit to chain frames without a gap.
   assign pop = !empty &&
                ((state == S_IDLE) || ((state == S_STOP) && bit_end));

   // Byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the count alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + 1'b1;
         end else if (pop && !push) begin
            fifo_count <= fifo_count - 1'b1;
         end
      end
   end

   // Frame sequencer with baud timing and a registered line output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
`ifdef AUX_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  shift    <= head;
                  baud_cnt <= RELOAD;
                  state    <= S_START;
`ifdef AUX_UART_TX_PARITY_EN
                  parity_bit <= ^head;
`endif
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= RELOAD;
                  bit_idx  <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= RELOAD;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
`ifdef AUX_UART_TX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`ifdef AUX_UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= RELOAD;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift    <= head;
                     baud_cnt <= RELOAD;
                     state    <= S_START;
`ifdef AUX_UART_TX_PARITY_EN
                     parity_bit <= ^head;
`endif
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         unique case (state)
            S_START:  tx <= 1'b0;
            S_DATA:   tx <= shift[0];
`ifdef AUX_UART_TX_PARITY_EN
            S_PARITY: tx <= parity_bit;
`endif
            default:  tx <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_aux_uart_tx.sv
// Bench for aux_uart_tx: line decoder + scoreboard, directed waveforms, random traffic.
// Build with AUX_UART_TX_PARITY_EN defined to exercise 8E1 framing.
module tb_aux_uart_tx;

   localparam int DIV = 10;
`ifdef AUX_UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int FB  = 11;
`else
   localparam bit PAR = 1'b0;
   localparam int FB  = 10;
`endif

   logic       clk;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   aux_uart_tx #(
      .CLK_FREQUENCY(1000),
      .BAUD_RATE(100),
      .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Reference: value of bit i of a serial frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return ((int'(b) / (1 << (i - 1))) % 2) == 1;
      if (PAR && i == 9) return ($countones(b) % 2) == 1;
      return 1'b1;
   endfunction

   task automatic wait_n(input int n, inout bit ab);
      repeat (n) begin
         @(negedge clk);
         if (!reset_n) ab = 1'b1;
      end
   endtask

   // Monitor: decode frames from the line and score them against exp_q.
   initial begin : monitor
      logic [7:0] d;
      logic [7:0] e;
      logic st, pb, sb;
      bit ab;
      forever begin
         @(negedge clk);
         if (reset_n && tx === 1'b0) begin
            ab = 1'b0;
            pb = 1'b0;
            wait_n(DIV / 2, ab);
            st = tx;
            for (int i = 0; i < 8; i++) begin
               wait_n(DIV, ab);
               d[i] = tx;
            end
            if (PAR) begin
               wait_n(DIV, ab);
               pb = tx;
            end
            wait_n(DIV, ab);
            sb = tx;
            if (!ab) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_data", {24'd0, d}, {24'd0, e});
                  chk("start_bit", {31'd0, st}, 32'd0);
                  chk("stop_bit", {31'd0, sb}, 32'd1);
                  if (PAR)
                     chk("parity_bit", {31'd0, pb},
                         32'($countones(e) % 2));
               end
            end
         end
      end
   end

   // Offer one byte from a negedge, hold until accepted, record it.
   task automatic send(input logic [7:0] b);
      int n;
      tx_data  = b;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         chk("send_timeout", 32'd1, 32'd0);
         tx_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back(b);
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   // Next posedge is the first start-bit cycle; check every cycle of the burst.
   task automatic check_wave(input logic [7:0] bq[$]);
      int n;
      int fi;
      int bi;
      logic ok;
      logic busy_ok;
      n = bq.size() * FB * DIV;
      ok = 1'b1;
      busy_ok = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         fi = c / (FB * DIV);
         bi = (c % (FB * DIV)) / DIV;
         if (tx !== frame_bit(bq[fi], bi)) ok = 1'b0;
         if (c < n - 1 && busy !== 1'b1) busy_ok = 1'b0;
         if (c == n - 1) chk("busy_end", {31'd0, busy}, 32'd0);
         if ((c % DIV) == DIV - 1) begin
            checks++;
            if (!ok) begin
               errors++;
               $display("FAIL wave f%0d b%0d: got %0b expected %0b",
                        fi, bi, tx, frame_bit(bq[fi], bi));
            end
            ok = 1'b1;
         end
      end
      chk("busy_during", {31'd0, busy_ok}, 32'd1);
      @(posedge clk);
      #1;
      chk("wave_idle", {31'd0, tx}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, (n >= 4000)}, 32'd0);
      repeat (2 * DIV) @(negedge clk);
   endtask

   initial begin : watchdog
      #(100000 * 10);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] q[$];
      logic hold_ok;
      int gap;
      reset_n  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {28'd0, fifo_count}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single 0x55 frame, exact latency and shape.
      send(8'h55);
      @(posedge clk);
      #1;
      chk("lat_k1", {31'd0, tx}, 32'd1);
      q = '{8'h55};
      check_wave(q);
      wait_idle();

      // Two back-to-back frames; second push coincides with the first pop.
      send(8'h00);
      send(8'hFF);
      chk("pushpop_count", {28'd0, fifo_count}, 32'd1);
      q = '{8'h00, 8'hFF};
      check_wave(q);
      wait_idle();

      // Parity-relevant bytes; frame length follows the build.
      send(8'h07);
      send(8'h03);
      q = '{8'h07, 8'h03};
      check_wave(q);
      wait_idle();

      // Fill to full, hold a stalled byte, then let it in after a pop.
      for (int j = 0; j < 9; j++) begin
         send(8'h10 + 8'(j));
         chk("fill_count", {28'd0, fifo_count}, (j == 0) ? 32'd1 : 32'(j));
      end
      chk("full_ready", {31'd0, tx_ready}, 32'd0);
      tx_data  = 8'h19;
      tx_valid = 1'b1;
      hold_ok  = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (fifo_count !== 4'd8) hold_ok = 1'b0;
      end
      chk("full_hold", {31'd0, hold_ok}, 32'd1);
      send(8'h19);
      chk("refill_count", {28'd0, fifo_count}, 32'd8);
      wait_idle();

      // Reset during data bit 3 of 0xA5.
      send(8'hA5);
      repeat (46) @(posedge clk);
      #1;
      chk("pre_rst_bit3", {31'd0, tx}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_tx", {31'd0, tx}, 32'd1);
      chk("async_count", {28'd0, fifo_count}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      hold_ok = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) hold_ok = 1'b0;
      end
      chk("post_rst_quiet", {31'd0, hold_ok}, 32'd1);

      // Random traffic with random gaps, scored by the monitor.
      for (int i = 0; i < 40; i++) begin
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 150)
                                           : $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         send(8'($urandom));
         if (fifo_count > 4'd8) chk("count_range", {28'd0, fifo_count}, 32'd8);
      end
      wait_idle();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("final_tx", {31'd0, tx}, 32'd1);
      chk("final_ready", {31'd0, tx_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
